// File: rtl/r8mbe_seq_mult_ctrl.sv
// Sequential radix-8 modified-Booth unsigned multiplier controller.
// One shared multiple generator (1X..4X) feeds an accumulator that retires one Booth digit per clock.
module r8mbe_seq_mult_ctrl #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod,
  output logic           busy,
  output logic [3:0]     digit_idx
);

  localparam int NDIG = (N + 3) / 3;
  localparam int AW   = 2 * N + 3;
  localparam int MW   = N + 2;
  localparam logic [3:0] LAST_DIGIT = 4'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  state_t          state;
  logic [N-1:0]    x_reg;
  logic [N-1:0]    y_reg;
  logic [MW-1:0]   m1;
  logic [MW-1:0]   m2;
  logic [MW-1:0]   m3;
  logic [MW-1:0]   m4;
  logic [AW-1:0]   acc;

  logic [N+3:0]    y_pad;
  logic [5:0]      shamt;
  logic [3:0]      win;
  logic [MW-1:0]   mag;
  logic            neg;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   acc_next;

  assign in_ready = (state == IDLE) && !rst;

  // Y is padded with Y[-1]=0 below and zeros above so the top digit sees zero-extended bits.
  always_comb begin
    y_pad = {3'b000, y_reg, 1'b0};
    shamt = 6'(digit_idx) * 6'd3;
    win   = 4'(y_pad >> shamt);
    mag   = '0;
    neg   = 1'b0;
    case (win)
      4'b0001, 4'b0010: mag = m1;
      4'b0011, 4'b0100: mag = m2;
      4'b0101, 4'b0110: mag = m3;
      4'b0111:          mag = m4;
      4'b1000:          begin mag = m4; neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = m3; neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = m2; neg = 1'b1; end
      4'b1101, 4'b1110: begin mag = m1; neg = 1'b1; end
      default:          mag = '0;
    endcase
    pp = {{(AW - MW){1'b0}}, mag};
    if (neg) pp = -pp;
    addend   = pp << shamt;
    acc_next = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      m1        <= '0;
      m2        <= '0;
      m3        <= '0;
      m4        <= '0;
      acc       <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      digit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= a_in;
            y_reg <= b_in;
            acc   <= '0;
            busy  <= 1'b1;
            state <= PRE;
          end
        end
        PRE: begin
          m1        <= {2'b00, x_reg};
          m2        <= {1'b0, x_reg, 1'b0};
          m3        <= {2'b00, x_reg} + {1'b0, x_reg, 1'b0};
          m4        <= {x_reg, 2'b00};
          digit_idx <= '0;
          state     <= ITER;
        end
        ITER: begin
          acc       <= acc_next;
          digit_idx <= digit_idx + 4'd1;
          if (digit_idx == LAST_DIGIT) begin
            prod      <= acc_next[2*N-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The finished accumulator must be a non-negative value that fits the 2N-bit product.
  assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> (acc[AW-1:2*N] == '0));

endmodule

// File: tb/tb_r8mbe_seq_mult_ctrl.sv
// Self-checking bench for r8mbe_seq_mult_ctrl: directed and random products against a plain
// arithmetic model, plus latency, backpressure, busy-ignore, mid-operation reset and throughput.
module tb_r8mbe_seq_mult_ctrl;

  localparam int N    = 24;
  localparam int NDIG = (N + 3) / 3;
  localparam int LAT  = NDIG + 1;
  localparam int PER  = NDIG + 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a_in = '0;
  logic [N-1:0]   b_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] prod;
  logic           busy;
  logic [3:0]     digit_idx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  r8mbe_seq_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    return (2*N)'(a) * (2*N)'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL %s_idle_timeout: in_ready=%b expected 1", name, in_ready);
    else pass_cnt++;
  endtask

  // Accept one operand pair and return how many clocks until out_valid appears.
  task automatic accept_and_wait(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output int lat, output bit busy_bad);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    tick();
    in_valid = 1'b0;
    a_in = N'($urandom);
    b_in = N'($urandom);
    lat = 0;
    busy_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string name);
    int lat;
    bit busy_bad;
    logic [2*N-1:0] exp_p;
    exp_p = model(a, b);
    wait_idle(name);
    accept_and_wait(a, b, lat, busy_bad);
    total_cnt++;
    if (lat !== LAT) $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (prod !== exp_p) $display("[TB] FAIL %s_prod: got %h expected %h (a=%h b=%h)", name, prod, exp_p, a, b);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad) $display("[TB] FAIL %s_busy: in_ready/busy wrong while busy, got 1 expected 0", name);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || prod !== '0 || digit_idx !== 4'd0 || in_ready !== 1'b0)
      $display("[TB] FAIL reset_state: ov=%b busy=%b prod=%h idx=%0d ir=%b expected 0/0/0/0/0",
               out_valid, busy, prod, digit_idx, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    run_op(24'd1, 24'd2, "x1y2");
    run_op(24'd2, 24'd1, "x2y1");
    run_op(24'd5, 24'd3, "x5y3");
    run_op(24'd7, 24'd4, "x7y4");
    run_op(24'hFFFFFF, 24'hFFFFFF, "max_max");
    run_op(24'hFFFFFF, 24'd0, "max_zero");
    run_op(24'd0, N'($urandom), "zero_rand");
    run_op(24'h800000, 24'h800000, "msb_msb");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = N'($urandom);
      if (i % 5 == 0) b[N-1] = 1'b1;
      run_op(a, b, "random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit busy_bad;
    bit stable_bad;
    logic [N-1:0] a, b;
    logic [2*N-1:0] exp_p;
    a = N'($urandom);
    b = N'($urandom);
    exp_p = model(a, b);
    wait_idle("bp");
    out_ready = 1'b0;
    accept_and_wait(a, b, lat, busy_bad);
    total_cnt++;
    if (lat !== LAT) $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, LAT);
    else pass_cnt++;
    stable_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || prod !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) stable_bad = 1'b1;
    end
    total_cnt++;
    if (stable_bad) $display("[TB] FAIL bp_hold: ov=%b prod=%h ir=%b expected 1/%h/0", out_valid, prod, in_ready, exp_p);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL bp_release: ov=%b ir=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
    else pass_cnt++;
    total_cnt++;
    if (prod !== exp_p) $display("[TB] FAIL bp_prod_kept: got %h expected %h", prod, exp_p);
    else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [N-1:0] a, b;
    logic [2*N-1:0] exp_p;
    a = N'($urandom);
    b = N'($urandom);
    exp_p = model(a, b);
    wait_idle("ignore");
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    a_in = ~a;
    b_in = b ^ 24'h5A5A5A;
    tick();
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (prod !== exp_p || out_valid !== 1'b1)
      $display("[TB] FAIL ignore_prod: got %h (ov=%b) expected %h", prod, out_valid, exp_p);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL ignore_release: in_ready=%b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int n;
    wait_idle("midrst");
    in_valid = 1'b1;
    a_in = N'($urandom);
    b_in = N'($urandom);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (digit_idx !== 4'd4 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (digit_idx !== 4'd4 || busy !== 1'b1)
      $display("[TB] FAIL midrst_reach_digit4: idx=%0d busy=%b expected 4/1", digit_idx, busy);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || prod !== '0 || busy !== 1'b0 || digit_idx !== 4'd0 || in_ready !== 1'b1)
      $display("[TB] FAIL midrst_state: ov=%b prod=%h busy=%b idx=%0d ir=%b expected 0/0/0/0/1",
               out_valid, prod, busy, digit_idx, in_ready);
    else pass_cnt++;
    run_op(24'd3, 24'd3, "after_rst");
  endtask

  task automatic test_back_to_back();
    int first, second, outs;
    bit prod_bad;
    logic [N-1:0] a, b;
    logic [2*N-1:0] exp_p;
    a = N'($urandom);
    b = N'($urandom);
    exp_p = model(a, b);
    wait_idle("b2b");
    out_ready = 1'b1;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    first = -1;
    second = -1;
    outs = 0;
    prod_bad = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin
      if (in_ready === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (out_valid === 1'b1) begin
        outs++;
        if (prod !== exp_p) prod_bad = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (second - first !== PER)
      $display("[TB] FAIL b2b_period: got %0d expected %0d", second - first, PER);
    else pass_cnt++;
    total_cnt++;
    if (prod_bad || outs < 2) $display("[TB] FAIL b2b_prod: outputs=%0d prod=%h expected >=2 of %h", outs, prod, exp_p);
    else pass_cnt++;
    wait_idle("b2b_drain");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
